// File: rtl/fanbit_rca_pkg.sv
// Shared constants for the fanbit_rca ripple-carry adder.
package fanbit_rca_pkg;

  localparam int unsigned SIZE_DEFAULT = 4;
  localparam int unsigned SIZE_MIN     = 1;
  localparam int unsigned SIZE_MAX     = 32;

endpackage : fanbit_rca_pkg

// File: rtl/fanbit_rca_fa_1bit.sv
// Single-bit full adder used as one stage of the ripple chain.
module fa_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule : fa_1bit

// File: rtl/fanbit_rca.sv
// SIZE-bit ripple-carry adder with registered sum and carry-out.
module fanbit_rca
  import fanbit_rca_pkg::*;
#(
  parameter int unsigned SIZE = SIZE_DEFAULT
) (
  input  logic            PortClk_nbit,
  input  logic            PortRst_nbit,
  input  logic [SIZE-1:0] PortA_nbit,
  input  logic [SIZE-1:0] PortB_nbit,
  input  logic            PortCin_nbit,
  output logic [SIZE-1:0] PortS_nbit,
  output logic            PortCout_nbit
);

  logic [SIZE:0]   c;
  logic [SIZE-1:0] s;

  assign c[0] = PortCin_nbit;

  // One full adder per bit, carry chained from bit 0 upward.
  for (genvar i = 0; i < SIZE; i++) begin : g_stage
    fa_1bit u_fa (
      .a    (PortA_nbit[i]),
      .b    (PortB_nbit[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  always_ff @(posedge PortClk_nbit or posedge PortRst_nbit) begin
    if (PortRst_nbit) begin
      PortS_nbit    <= '0;
      PortCout_nbit <= 1'b0;
    end else begin
      PortS_nbit    <= s;
      PortCout_nbit <= c[SIZE];
    end
  end

endmodule : fanbit_rca

// File: tb/tb_fanbit_rca.sv
// Directed plus randomized checks of fanbit_rca at SIZE = 2 and SIZE = 8.
module tb_fanbit_rca;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] a2, b2, s2;
  logic       cin2, cout2;
  logic [7:0] a8, b8, s8;
  logic       cin8, cout8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fanbit_rca #(.SIZE(2)) dut2 (
    .PortClk_nbit  (clk),
    .PortRst_nbit  (rst),
    .PortA_nbit    (a2),
    .PortB_nbit    (b2),
    .PortCin_nbit  (cin2),
    .PortS_nbit    (s2),
    .PortCout_nbit (cout2)
  );

  fanbit_rca #(.SIZE(8)) dut8 (
    .PortClk_nbit  (clk),
    .PortRst_nbit  (rst),
    .PortA_nbit    (a8),
    .PortB_nbit    (b8),
    .PortCin_nbit  (cin8),
    .PortS_nbit    (s8),
    .PortCout_nbit (cout8)
  );

  // Reference: the adder's {cout, sum} is simply the integer sum.
  function automatic logic [8:0] ref_sum(input int unsigned a, input int unsigned b,
                                         input int unsigned cin);
    return 9'(a + b + cin);
  endfunction

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset asserted with maximal inputs: outputs forced to zero.
    rst = 1'b1;
    a2 = 2'd3; b2 = 2'd3; cin2 = 1'b1;
    a8 = 8'd255; b8 = 8'd255; cin8 = 1'b1;
    #1;
    check("reset_imm_2", 9'({cout2, s2}), 9'd0);
    check("reset_imm_8", 9'({cout8, s8}), 9'd0);
    for (int k = 0; k < 2; k++) begin
      edge_sample();
      check("reset_hold_2", 9'({cout2, s2}), 9'd0);
      check("reset_hold_8", 9'({cout8, s8}), 9'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Exhaustive sweep at SIZE = 2.
    for (int c = 0; c < 2; c++) begin
      for (int a = 0; a < 4; a++) begin
        for (int b = 0; b < 4; b++) begin
          @(negedge clk);
          a2 = 2'(a); b2 = 2'(b); cin2 = 1'(c);
          edge_sample();
          check($sformatf("sweep_a%0d_b%0d_c%0d", a, b, c), 9'({cout2, s2}),
                ref_sum(a, b, c));
        end
      end
    end

    // Full-carry ripple cases.
    @(negedge clk);
    a2 = 2'd3; b2 = 2'd0; cin2 = 1'b1;
    edge_sample();
    check("wrap_3_0_1", 9'({cout2, s2}), 9'd4);
    @(negedge clk);
    a2 = 2'd3; b2 = 2'd3; cin2 = 1'b1;
    edge_sample();
    check("max_3_3_1", 9'({cout2, s2}), 9'd7);

    // Latency: input change between edges is not visible until the next edge.
    @(negedge clk);
    a2 = 2'd0; b2 = 2'd0; cin2 = 1'b0;
    edge_sample();
    check("lat_zero", 9'({cout2, s2}), 9'd0);
    @(negedge clk);
    a2 = 2'd1; b2 = 2'd1;
    #1;
    check("lat_hold", 9'({cout2, s2}), 9'd0);
    edge_sample();
    check("lat_update", 9'({cout2, s2}), 9'd2);

    // Mid-run asynchronous reset, then recovery on the next edge.
    @(negedge clk);
    a2 = 2'd1; b2 = 2'd2; cin2 = 1'b0;
    edge_sample();
    check("pre_rst_sum", 9'({cout2, s2}), 9'd3);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_async", 9'({cout2, s2}), 9'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_hold", 9'({cout2, s2}), 9'd0);
    edge_sample();
    check("post_rst_sum", 9'({cout2, s2}), 9'd3);

    // SIZE = 8 directed cases.
    @(negedge clk);
    a8 = 8'd255; b8 = 8'd1; cin8 = 1'b0;
    edge_sample();
    check("w8_255_1_0", 9'({cout8, s8}), 9'h100);
    @(negedge clk);
    a8 = 8'd100; b8 = 8'd27; cin8 = 1'b1;
    edge_sample();
    check("w8_100_27_1", 9'({cout8, s8}), 9'd128);
    @(negedge clk);
    a8 = 8'd0; b8 = 8'd0; cin8 = 1'b0;
    edge_sample();
    check("w8_zero", 9'({cout8, s8}), 9'd0);

    // SIZE = 8 randomized against the integer reference.
    for (int n = 0; n < 40; n++) begin
      int unsigned ra, rb, rc;
      ra = $urandom_range(255);
      rb = $urandom_range(255);
      rc = $urandom_range(1);
      @(negedge clk);
      a8 = 8'(ra); b8 = 8'(rb); cin8 = 1'(rc);
      edge_sample();
      check($sformatf("w8_rand_%0d_%0d_%0d", ra, rb, rc), 9'({cout8, s8}),
            ref_sum(ra, rb, rc));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fanbit_rca
